fifo_wptr_full: RTL and testbench

- Write-side control stage directly upstream of FIFO_Memory in the dual-clock FIFO.
- Owns the write pointer and produces `waddr` for the memory array.
- Generates the Gray-coded write pointer for the read domain.
- Synchronises the read domain's Gray pointer into wclk and raises `full` so the memory never overwrites unread data.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/fifo_sync_2ff.sv | 24 ++
 rtl/fifo_wptr_full.sv | 90 +++++++++
 tb/tb_fifo_wptr_full.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared dual-clock FIFO definitions: default sizes, pointer type and Gray-code helpers
// used by both the write-side and read-side pointer blocks.
package fifo_pkg;

   localparam int FIFO_ADDRWIDTH = 9;
   localparam int FIFO_DWIDTH    = 8;
   localparam int CODE_W         = 32;

   typedef logic [FIFO_ADDRWIDTH:0] ptr_t;

   function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] bin);
      return bin ^ {1'b0, bin[CODE_W-1:1]};
   endfunction

   // Callers zero-extend narrower pointers; leading zeros leave the conversion unchanged.
   function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] gray);
      logic [CODE_W-1:0] bin;
      bin[CODE_W-1] = gray[CODE_W-1];
      for (int i = CODE_W - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/fifo_sync_2ff.sv
// Two-flop synchroniser for a Gray-coded pointer crossing into the local clock domain.
module fifo_sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_r;

   // Metastability stage followed by the stage the local logic consumes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_r <= '0;
         q      <= '0;
      end else begin
         meta_r <= d;
         q      <= meta_r;
      end
   end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full-flag stage of the dual-clock FIFO.
// Optional almost_full output is built only when ALMOST_FULL_EN is defined.
module fifo_wptr_full
   import fifo_pkg::*;
#(
   parameter int ADDRWIDTH = FIFO_ADDRWIDTH,
   parameter int AF_MARGIN = 4
) (
   input  logic                 wclk,
   input  logic                 wrst_n,
   input  logic                 w_enable,
   input  logic [ADDRWIDTH:0]   rptr_gray,
   output logic [ADDRWIDTH-1:0] waddr,
   output logic [ADDRWIDTH:0]   wptr_gray,
   output logic                 full,
   output logic [ADDRWIDTH:0]   wcount
`ifdef ALMOST_FULL_EN
   ,
   output logic                 almost_full
`endif
);

   localparam int PW    = ADDRWIDTH + 1;
   localparam int DEPTH = 1 << ADDRWIDTH;

   if (AF_MARGIN < 1 || AF_MARGIN >= DEPTH) begin : g_bad_margin
      $error("fifo_wptr_full: AF_MARGIN out of range");
   end

   logic [ADDRWIDTH:0] wbin_r;
   logic [ADDRWIDTH:0] rq2_s;
   logic [ADDRWIDTH:0] wbin_next_s;
   logic [ADDRWIDTH:0] wgray_next_s;
   logic [ADDRWIDTH:0] rbin_s;
   logic [ADDRWIDTH:0] wcount_next_s;
   logic               inc_s;
   logic               full_next_s;

   fifo_sync_2ff #(
      .WIDTH (PW)
   ) u_rptr_sync (
      .clk   (wclk),
      .rst_n (wrst_n),
      .d     (rptr_gray),
      .q     (rq2_s)
   );

   assign waddr = wbin_r[ADDRWIDTH-1:0];

   // Next pointer and flag terms from the current pointer and the synchronised read pointer.
   always_comb begin
      inc_s         = w_enable & ~full;
      wbin_next_s   = wbin_r + PW'(inc_s);
      wgray_next_s  = PW'(bin2gray(CODE_W'(wbin_next_s)));
      rbin_s        = PW'(gray2bin(CODE_W'(rq2_s)));
      wcount_next_s = wbin_next_s - rbin_s;
      full_next_s   = (wgray_next_s == {~rq2_s[ADDRWIDTH:ADDRWIDTH-1], rq2_s[ADDRWIDTH-2:0]});
   end

   // Pointer, Gray pointer and write-side flags; full only clears once rq2 moves.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wbin_r    <= '0;
         wptr_gray <= '0;
         full      <= 1'b0;
         wcount    <= '0;
      end else begin
         wbin_r    <= wbin_next_s;
         wptr_gray <= wgray_next_s;
         full      <= full_next_s;
         wcount    <= wcount_next_s;
      end
   end

`ifdef ALMOST_FULL_EN
   logic almost_full_next_s;

   assign almost_full_next_s = (wcount_next_s >= PW'(DEPTH - AF_MARGIN));

   // Early warning flag, a superset of full.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         almost_full <= 1'b0;
      end else begin
         almost_full <= almost_full_next_s;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Scoreboard bench for fifo_wptr_full: a 512-deep instance for fill/full/drain/reset
// and an 8-deep instance for pointer wrap-around.
module tb_fifo_wptr_full;

   localparam int AW_A = 9;
   localparam int AW_B = 3;

   logic              wclk = 1'b0;
   logic              wrst_n;
   logic              we_a, we_b;
   logic [AW_A:0]     rg_a;
   logic [AW_B:0]     rg_b;
   logic [AW_A-1:0]   waddr_a;
   logic [AW_B-1:0]   waddr_b;
   logic [AW_A:0]     wgray_a, wcount_a;
   logic [AW_B:0]     wgray_b, wcount_b;
   logic              full_a, full_b;
`ifdef ALMOST_FULL_EN
   logic              af_a, af_b;
`endif

   always #5 wclk = ~wclk;

   fifo_wptr_full #(.ADDRWIDTH(AW_A), .AF_MARGIN(4)) dut_a (
      .wclk(wclk), .wrst_n(wrst_n), .w_enable(we_a), .rptr_gray(rg_a),
      .waddr(waddr_a), .wptr_gray(wgray_a), .full(full_a), .wcount(wcount_a)
`ifdef ALMOST_FULL_EN
      , .almost_full(af_a)
`endif
   );

   fifo_wptr_full #(.ADDRWIDTH(AW_B), .AF_MARGIN(4)) dut_b (
      .wclk(wclk), .wrst_n(wrst_n), .w_enable(we_b), .rptr_gray(rg_b),
      .waddr(waddr_b), .wptr_gray(wgray_b), .full(full_b), .wcount(wcount_b)
`ifdef ALMOST_FULL_EN
      , .almost_full(af_b)
`endif
   );

   typedef struct {
      int          k;
      int unsigned waddr;
      int unsigned wgray;
      int unsigned full;
      int unsigned wcount;
      int unsigned af;
   } exp_t;

   exp_t        sb[$];
   int unsigned m_wbin[2];
   int unsigned m_rp1[2];
   int unsigned m_rp2[2];
   bit          m_full[2];
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Occupancy-based model: full means the binary distance to the delayed read pointer is DEPTH.
   task automatic model_step(input int k, input bit we, input int unsigned rbin);
      int unsigned depth, mask, nb, occ;
      exp_t        e;
      depth = (k == 0) ? (1 << AW_A) : (1 << AW_B);
      mask  = 2 * depth - 1;
      nb    = (m_wbin[k] + ((we && !m_full[k]) ? 1 : 0)) & mask;
      occ   = (nb - m_rp2[k]) & mask;
      m_full[k] = (occ == depth);
      e.k      = k;
      e.waddr  = nb & (depth - 1);
      e.wgray  = nb ^ (nb >> 1);
      e.full   = m_full[k] ? 1 : 0;
      e.wcount = occ;
      e.af     = (occ >= depth - 4) ? 1 : 0;
      sb.push_back(e);
      m_rp2[k]  = m_rp1[k];
      m_rp1[k]  = rbin & mask;
      m_wbin[k] = nb;
   endtask

   task automatic compare(input exp_t e);
      if (e.k == 0) begin
         check_eq("waddr_a",  32'(waddr_a),  e.waddr);
         check_eq("wgray_a",  32'(wgray_a),  e.wgray);
         check_eq("full_a",   32'(full_a),   e.full);
         check_eq("wcount_a", 32'(wcount_a), e.wcount);
`ifdef ALMOST_FULL_EN
         check_eq("af_a",     32'(af_a),     e.af);
`endif
      end else begin
         check_eq("waddr_b",  32'(waddr_b),  e.waddr);
         check_eq("wgray_b",  32'(wgray_b),  e.wgray);
         check_eq("full_b",   32'(full_b),   e.full);
         check_eq("wcount_b", 32'(wcount_b), e.wcount);
`ifdef ALMOST_FULL_EN
         check_eq("af_b",     32'(af_b),     e.af);
`endif
      end
   endtask

   task automatic cycle(input bit wa, input int unsigned ra, input bit wb, input int unsigned rb);
      exp_t e;
      we_a = wa;
      rg_a = (AW_A + 1)'(ra ^ (ra >> 1));
      we_b = wb;
      rg_b = (AW_B + 1)'(rb ^ (rb >> 1));
      model_step(0, wa, ra);
      model_step(1, wb, rb);
      @(posedge wclk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         compare(e);
      end
   endtask

   // Asserts reset between edges with the current inputs still applied and checks it acts at once.
   task automatic do_reset(input string tag);
      wrst_n = 1'b0;
      #1;
      check_eq({tag, "_waddr_a"},  32'(waddr_a),  32'd0);
      check_eq({tag, "_wgray_a"},  32'(wgray_a),  32'd0);
      check_eq({tag, "_full_a"},   32'(full_a),   32'd0);
      check_eq({tag, "_wcount_a"}, 32'(wcount_a), 32'd0);
      check_eq({tag, "_waddr_b"},  32'(waddr_b),  32'd0);
`ifdef ALMOST_FULL_EN
      check_eq({tag, "_af_a"},     32'(af_a),     32'd0);
`endif
      we_a = 1'b0;
      we_b = 1'b0;
      rg_a = '0;
      rg_b = '0;
      for (int k = 0; k < 2; k++) begin
         m_wbin[k] = 0;
         m_rp1[k]  = 0;
         m_rp2[k]  = 0;
         m_full[k] = 1'b0;
      end
      sb.delete();
      @(negedge wclk);
      wrst_n = 1'b1;
      @(posedge wclk);
      #1;
   endtask

   initial begin
      int             n;
      logic [AW_B:0]  prev_gray;
      wrst_n = 1'b1;
      we_a   = 1'b0;
      we_b   = 1'b0;
      rg_a   = '0;
      rg_b   = '0;
      #3;
      do_reset("init");

      // Partial burst, then reset in the middle of it.
      repeat (20) cycle(1'b1, 0, 1'b0, 0);
      we_a = 1'b1;
      do_reset("mid");

      // Fill with the reader parked at 0.
      for (int i = 1; i <= 512; i++) begin
         cycle(1'b1, 0, 1'b0, 0);
`ifdef ALMOST_FULL_EN
         if (i == 507) check_eq("af_before_508", 32'(af_a), 32'd0);
         if (i == 508) check_eq("af_at_508",     32'(af_a), 32'd1);
         if (i == 511) check_eq("full_before_512", 32'(full_a), 32'd0);
`endif
      end
      check_eq("fill_full",   32'(full_a),   32'd1);
      check_eq("fill_wcount", 32'(wcount_a), 32'd512);
      check_eq("fill_wgray",  32'(wgray_a),  32'h300);
      check_eq("fill_waddr",  32'(waddr_a),  32'd0);

      // Writes while full are ignored.
      repeat (10) cycle(1'b1, 0, 1'b0, 0);
      check_eq("held_wgray", 32'(wgray_a), 32'h300);
      check_eq("held_waddr", 32'(waddr_a), 32'd0);
      check_eq("held_full",  32'(full_a),  32'd1);

      // Reader advances by one: full must drop exactly three edges later.
      n = 0;
      do begin
         cycle(1'b0, 1, 1'b0, 0);
         n++;
      end while (full_a && n < 10);
      check_eq("drain_edges", 32'(n), 32'd3);
      cycle(1'b1, 1, 1'b0, 0);
      check_eq("refill_full",  32'(full_a),  32'd1);
      check_eq("refill_wgray", 32'(wgray_a), 32'h301);

      // Small FIFO with the reader chasing the writer through several wraps.
      do_reset("wrap");
      for (int i = 0; i < 40; i++) begin
         prev_gray = wgray_b;
         cycle(1'b0, 0, 1'b1, m_wbin[1]);
         check_eq("gray_1bit", 32'($countones(wgray_b ^ prev_gray)), 32'd1);
      end
      check_eq("wrap_wgray", 32'(wgray_b), 32'd12);
      check_eq("wrap_waddr", 32'(waddr_b), 32'd0);
      check_eq("wrap_full",  32'(full_b),  32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
